// File: rtl/alu_seq_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_muldiv_if
// Brief    : Request/response bundle between the decode/register-file stage
//            (master) and the sequential ALU / mul-div unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [3:0]      aluSel;
    logic [2:0]      func3;
    logic            is_m;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    // Requester side: issues operations and accepts results
    modport master (
        output in_valid, in1, in2, aluSel, func3, is_m, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // Execution unit side
    modport slave (
        input  in_valid, in1, in2, aluSel, func3, is_m, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_muldiv
// Brief    : Handshaked RV32I ALU / branch comparator with one-cycle
//            registered latency, plus an iterative RV32M multiply/divide unit
//            retiring one bit per cycle (XLEN+1 clocks accept-to-valid).
//            Build macro ALU_MULDIV_EN includes the RV32M datapath; without
//            it every is_m request completes in one cycle as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_muldiv #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    alu_seq_muldiv_if.slave bus
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [3:0] C_OP_ADD    = 4'b0000;
    localparam logic [3:0] C_OP_SUB    = 4'b0001;
    localparam logic [3:0] C_OP_BRANCH = 4'b0010;
    localparam logic [3:0] C_OP_OR     = 4'b0100;
    localparam logic [3:0] C_OP_AND    = 4'b0101;
    localparam logic [3:0] C_OP_XOR    = 4'b0111;
    localparam logic [3:0] C_OP_SRL    = 4'b1000;
    localparam logic [3:0] C_OP_SLL    = 4'b1001;
    localparam logic [3:0] C_OP_SRA    = 4'b1010;
    localparam logic [3:0] C_OP_SLT    = 4'b1101;
    localparam logic [3:0] C_OP_SLTU   = 4'b1111;

    // ------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [XLEN-1:0]  r_result;
    logic             r_zero;
    logic             r_illegal;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_go_busy;    // accepted op needs the iterative unit
    logic             w_busy_last;  // current BUSY cycle is the final one

    // Base ALU signals
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_diff_ab;
    logic               w_eq;
    logic               w_lt;
    logic               w_ltu;
    logic [XLEN-1:0]    w_base_res;
    logic               w_base_zero;
    logic               w_base_ill;

    assign w_shamt   = bus.in2[SHAMT_W-1:0];
    assign w_diff_ab = bus.in1 - bus.in2;
    assign w_eq      = (bus.in1 == bus.in2);
    assign w_lt      = ($signed(bus.in1) < $signed(bus.in2));
    assign w_ltu     = (bus.in1 < bus.in2);
    assign w_accept  = bus.in_valid && w_in_ready;

    // Single-cycle base operation result, zero/condition flag and legality
    always_comb begin
        w_base_res  = '0;
        w_base_ill  = 1'b0;
        case (bus.aluSel)
            C_OP_ADD:              w_base_res = bus.in1 + bus.in2;
            C_OP_SUB, C_OP_BRANCH: w_base_res = w_diff_ab;
            C_OP_OR:               w_base_res = bus.in1 | bus.in2;
            C_OP_AND:              w_base_res = bus.in1 & bus.in2;
            C_OP_XOR:              w_base_res = bus.in1 ^ bus.in2;
            C_OP_SRL:              w_base_res = bus.in1 >> w_shamt;
            C_OP_SLL:              w_base_res = bus.in1 << w_shamt;
            C_OP_SRA:              w_base_res = XLEN'($signed(bus.in1) >>> w_shamt);
            C_OP_SLT:              w_base_res = {{(XLEN-1){1'b0}}, w_lt};
            C_OP_SLTU:             w_base_res = {{(XLEN-1){1'b0}}, w_ltu};
            default:               w_base_ill = 1'b1;
        endcase

        // For branches the flag carries the condition; otherwise result==0
        w_base_zero = (w_base_res == '0);
        if (bus.aluSel == C_OP_BRANCH) begin
            case (bus.func3)
                3'b000:  w_base_zero = w_eq;
                3'b001:  w_base_zero = !w_eq;
                3'b100:  w_base_zero = w_lt;
                3'b101:  w_base_zero = !w_lt;
                3'b110:  w_base_zero = w_ltu;
                3'b111:  w_base_zero = !w_ltu;
                default: begin
                    w_base_zero = 1'b0;
                    w_base_ill  = 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative RV32M unit. r_hi/r_lo form a shared 2*XLEN accumulator:
    //   multiply: {partial product, remaining multiplier bits}
    //   divide  : {partial remainder, dividend shifting into quotient}
    // ------------------------------------------------------------------
    localparam int                 C_CNT_W   = $clog2(XLEN);
    localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]    C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [C_CNT_W-1:0] r_count;
    logic [XLEN-1:0]    r_a;        // multiplicand or divisor magnitude
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [2:0]         r_op;
    logic               r_neg;      // negate the selected final value

    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_fast;
    logic [XLEN-1:0]    w_fast_res;

    logic [XLEN:0]      w_msum;
    logic [XLEN:0]      w_dshift;
    logic [XLEN:0]      w_ddiff;
    logic [XLEN-1:0]    w_nhi;
    logic [XLEN-1:0]    w_nlo;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_m_res;

    // Operand signedness, magnitudes and the divide corner cases
    always_comb begin
        w_is_div   = bus.func3[2];
        w_a_signed = w_is_div ? !bus.func3[0]
                              : (bus.func3 == 3'b001) || (bus.func3 == 3'b010);
        w_b_signed = w_is_div ? !bus.func3[0] : (bus.func3 == 3'b001);
        w_sa       = w_a_signed && bus.in1[XLEN-1];
        w_sb       = w_b_signed && bus.in2[XLEN-1];
        w_mag_a    = w_sa ? -bus.in1 : bus.in1;
        w_mag_b    = w_sb ? -bus.in2 : bus.in2;
        w_div_zero = (bus.in2 == '0);
        w_div_ovf  = !bus.func3[0] && (bus.in1 == C_MIN_NEG) && (bus.in2 == '1);
        w_fast     = w_is_div && (w_div_zero || w_div_ovf);
        // func3[1] separates remainder ops from quotient ops
        if (w_div_zero) begin
            w_fast_res = bus.func3[1] ? bus.in1 : '1;
        end else begin
            w_fast_res = bus.func3[1] ? '0 : bus.in1;
        end
    end

    assign w_go_busy   = bus.is_m && !w_fast;
    assign w_busy_last = (r_count == C_LAST);

    // One shift-add or restore-subtract step on the accumulator
    always_comb begin
        w_msum   = {1'b0, r_hi} + {1'b0, r_a & {XLEN{r_lo[0]}}};
        w_dshift = {r_hi, r_lo[XLEN-1]};
        w_ddiff  = w_dshift - {1'b0, r_a};
        if (r_op[2]) begin
            w_nhi = w_ddiff[XLEN] ? w_dshift[XLEN-1:0] : w_ddiff[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], !w_ddiff[XLEN]};
        end else begin
            {w_nhi, w_nlo} = {w_msum, r_lo[XLEN-1:1]};
        end
    end

    // Sign fix-up and op-dependent selection of the final stepped value
    always_comb begin
        w_prod = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
        case (r_op)
            3'b000:                 w_m_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_m_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_m_res = r_neg ? -w_nlo : w_nlo;
            default:                w_m_res = r_neg ? -w_nhi : w_nhi;
        endcase
    end

    // Latch magnitudes at accept, then iterate once per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
        end else if (w_accept && w_go_busy) begin
            r_count <= '0;
            r_op    <= bus.func3;
            r_hi    <= '0;
            if (w_is_div) begin
                r_a   <= w_mag_b;
                r_lo  <= w_mag_a;
                r_neg <= bus.func3[1] ? w_sa : (w_sa ^ w_sb);
            end else begin
                r_a   <= w_mag_a;
                r_lo  <= w_mag_b;
                r_neg <= w_sa ^ w_sb;
            end
        end else if (r_state == C_BUSY) begin
            r_count <= r_count + C_CNT_W'(1);
            r_hi    <= w_nhi;
            r_lo    <= w_nlo;
        end
    end
`else
    // No iterative unit: is_m requests never enter BUSY
    assign w_go_busy   = 1'b0;
    assign w_busy_last = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE -> BUSY/DONE on accept, BUSY -> DONE, DONE -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = w_go_busy ? C_BUSY : C_DONE;
                end
            end
            C_BUSY: begin
                if (w_busy_last) begin
                    w_state_next = C_DONE;
                end
            end
            C_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = C_IDLE;
                end
            end
            default: w_state_next = C_IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted
    always_comb begin
        w_in_ready  = (r_state == C_IDLE) && !rst;
        w_out_valid = (r_state == C_DONE);
    end

    // Result registers: written at accept (single-cycle ops) or final BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            if (!bus.is_m) begin
                r_result  <= w_base_res;
                r_zero    <= w_base_zero;
                r_illegal <= w_base_ill;
            end
`ifdef ALU_MULDIV_EN
            else if (w_fast) begin
                r_result  <= w_fast_res;
                r_zero    <= (w_fast_res == '0);
                r_illegal <= 1'b0;
            end
        end else if ((r_state == C_BUSY) && w_busy_last) begin
            r_result  <= w_m_res;
            r_zero    <= (w_m_res == '0);
            r_illegal <= 1'b0;
        end
`else
            else begin
                r_result  <= '0;
                r_zero    <= 1'b1;
                r_illegal <= 1'b1;
            end
        end
`endif
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_muldiv
// Brief    : Directed, table-driven bench for alu_seq_muldiv (XLEN=32), with
//            hand-written backpressure and mid-operation reset sequences.
//            Expectations follow the ALU_MULDIV_EN build macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_muldiv;

    localparam int XLEN = 32;

`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_seq_muldiv_if #(.XLEN(XLEN)) bus ();

    alu_seq_muldiv #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [2:0]  f3;
        logic        m;
        logic [31:0] res;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    function automatic vec_t bv(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] sel, input logic [2:0] f3,
                                input logic [31:0] res, input logic z, input logic il);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.sel = sel; v.f3 = f3; v.m = 1'b0;
        v.res = res; v.z = z; v.il = il; v.lat = 1;
        return v;
    endfunction

    // M-op vector; without the mul/div unit the op must complete as illegal
    function automatic vec_t mv(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, input logic [31:0] res, input logic z,
                                input int lat);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.sel = 4'b0000; v.f3 = f3; v.m = 1'b1;
        v.res = MD_EN ? res : 32'h0;
        v.z   = MD_EN ? z : 1'b1;
        v.il  = !MD_EN;
        v.lat = MD_EN ? lat : 1;
        return v;
    endfunction

    // Issue one op, measure clocks to out_valid, capture outputs, complete handshake
    task automatic do_op(input vec_t v, output logic [31:0] res, output logic z,
                         output logic il, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.in1 = v.a; bus.in2 = v.b; bus.aluSel = v.sel; bus.func3 = v.f3;
        bus.is_m = v.m; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // operands must already be latched
        bus.in1 = $urandom(); bus.in2 = $urandom();
        bus.aluSel = 4'($urandom()); bus.func3 = 3'($urandom()); bus.is_m = 1'($urandom());
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result; z = bus.zero; il = bus.illegal;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] r_res;
    logic        r_z;
    logic        r_il;
    int          r_lat;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in1 = '0; bus.in2 = '0; bus.aluSel = '0; bus.func3 = '0; bus.is_m = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst.in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.zero", {31'b0, bus.zero}, 32'd0);
        check("rst.illegal", {31'b0, bus.illegal}, 32'd0);

        // ---------------- vector table ----------------
        vecs.push_back(bv("add",      32'd10, 32'd5, 4'b0000, 3'd0, 32'd15, 1'b0, 1'b0));
        vecs.push_back(bv("sub",      32'd10, 32'd5, 4'b0001, 3'd0, 32'd5,  1'b0, 1'b0));
        vecs.push_back(bv("and",      32'd10, 32'd5, 4'b0101, 3'd0, 32'd0,  1'b1, 1'b0));
        vecs.push_back(bv("xor",      32'd10, 32'd5, 4'b0111, 3'd0, 32'd15, 1'b0, 1'b0));
        vecs.push_back(bv("or",       32'd10, 32'd5, 4'b0100, 3'd0, 32'd15, 1'b0, 1'b0));
        vecs.push_back(bv("sll",      32'd10, 32'd5, 4'b1001, 3'd0, 32'd320, 1'b0, 1'b0));
        vecs.push_back(bv("srl",      32'h8000_0000, 32'd4,  4'b1000, 3'd0, 32'h0800_0000, 1'b0, 1'b0));
        vecs.push_back(bv("srl_mask", 32'h8000_0000, 32'h24, 4'b1000, 3'd0, 32'h0800_0000, 1'b0, 1'b0));
        vecs.push_back(bv("sra",      32'h8000_0000, 32'd4,  4'b1010, 3'd0, 32'hF800_0000, 1'b0, 1'b0));
        vecs.push_back(bv("add_wrap", 32'hFFFF_FFFF, 32'd1,  4'b0000, 3'd0, 32'd0, 1'b1, 1'b0));
        vecs.push_back(bv("sltu",     32'hA, 32'hF000_0005, 4'b1111, 3'd0, 32'd1, 1'b0, 1'b0));
        vecs.push_back(bv("slt",      32'hA, 32'hF000_0005, 4'b1101, 3'd0, 32'd0, 1'b1, 1'b0));
        vecs.push_back(bv("br_ltu",   32'hA, 32'hF000_0005, 4'b0010, 3'b110, 32'h1000_0005, 1'b1, 1'b0));
        vecs.push_back(bv("br_lt",    32'hA, 32'hF000_0005, 4'b0010, 3'b100, 32'h1000_0005, 1'b0, 1'b0));
        vecs.push_back(bv("br_eq",    32'd7, 32'd7, 4'b0010, 3'b000, 32'd0, 1'b1, 1'b0));
        vecs.push_back(bv("br_ne",    32'd7, 32'd7, 4'b0010, 3'b001, 32'd0, 1'b0, 1'b0));
        vecs.push_back(bv("br_geu",   32'd5, 32'd10, 4'b0010, 3'b111, 32'hFFFF_FFFB, 1'b0, 1'b0));
        vecs.push_back(bv("br_ge",    32'hFFFF_FFFF, 32'd0, 4'b0010, 3'b101, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(bv("br_bad",   32'd10, 32'd5, 4'b0010, 3'b010, 32'd5, 1'b0, 1'b1));
        vecs.push_back(bv("bad_sel",  32'd10, 32'd5, 4'b0011, 3'd0, 32'd0, 1'b1, 1'b1));
        vecs.push_back(mv("mul",      32'hFFFF_FFFF, 32'd2, 3'b000, 32'hFFFF_FFFE, 1'b0, 33));
        vecs.push_back(mv("mulh",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 32'd0, 1'b1, 33));
        vecs.push_back(mv("mulhsu",   32'hFFFF_FFFF, 32'd2, 3'b010, 32'hFFFF_FFFF, 1'b0, 33));
        vecs.push_back(mv("mulhu",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE, 1'b0, 33));
        vecs.push_back(mv("div",      32'hFFFF_FFF9, 32'd2, 3'b100, 32'hFFFF_FFFD, 1'b0, 33));
        vecs.push_back(mv("rem",      32'hFFFF_FFF9, 32'd2, 3'b110, 32'hFFFF_FFFF, 1'b0, 33));
        vecs.push_back(mv("div_nd",   32'd7, 32'hFFFF_FFFE, 3'b100, 32'hFFFF_FFFD, 1'b0, 33));
        vecs.push_back(mv("rem_nd",   32'd7, 32'hFFFF_FFFE, 3'b110, 32'd1, 1'b0, 33));
        vecs.push_back(mv("divu",     32'd100, 32'd7, 3'b101, 32'd14, 1'b0, 33));
        vecs.push_back(mv("remu",     32'd100, 32'd7, 3'b111, 32'd2, 1'b0, 33));
        vecs.push_back(mv("divu_z",   32'd7, 32'd0, 3'b101, 32'hFFFF_FFFF, 1'b0, 1));
        vecs.push_back(mv("remu_z",   32'd7, 32'd0, 3'b111, 32'd7, 1'b0, 1));
        vecs.push_back(mv("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0000, 1'b0, 1));
        vecs.push_back(mv("rem_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'd0, 1'b1, 1));

        foreach (vecs[i]) begin
            do_op(vecs[i], r_res, r_z, r_il, r_lat);
            check({vecs[i].name, ".result"},  r_res, vecs[i].res);
            check({vecs[i].name, ".zero"},    {31'b0, r_z}, {31'b0, vecs[i].z});
            check({vecs[i].name, ".illegal"}, {31'b0, r_il}, {31'b0, vecs[i].il});
            check({vecs[i].name, ".latency"}, 32'(r_lat), 32'(vecs[i].lat));
        end

        // ---------------- backpressure ----------------
        @(negedge clk);
        bus.in1 = 32'd3; bus.in2 = 32'd4; bus.aluSel = 4'b0000; bus.is_m = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // a second request is left pending while the first result is unread
        bus.in1 = 32'd9; bus.in2 = 32'd1; bus.aluSel = 4'b0001;
        check("bp.out_valid", {31'b0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold_result", bus.result, 32'd7);
            check("bp.hold_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp.hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp.idle_valid", {31'b0, bus.out_valid}, 32'd0);
        check("bp.idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp.second_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp.second_result", bus.result, 32'd8);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // ---------------- reset in the middle of a divide ----------------
        @(negedge clk);
        bus.in1 = 32'd100; bus.in2 = 32'd7; bus.func3 = 3'b100; bus.is_m = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid.busy_valid", {31'b0, bus.out_valid}, MD_EN ? 32'd0 : 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid.rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid.rst_result", bus.result, 32'd0);
        check("mid.rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid.idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
        do_op(mv("mul3x4", 32'd3, 32'd4, 3'b000, 32'd12, 1'b0, 33), r_res, r_z, r_il, r_lat);
        check("mul3x4.result", r_res, MD_EN ? 32'd12 : 32'd0);
        check("mul3x4.illegal", {31'b0, r_il}, MD_EN ? 32'd0 : 32'd1);
        check("mul3x4.latency", 32'(r_lat), MD_EN ? 32'd33 : 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
